// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and attribute type for the sprite bank
package sprite_pkg;

  localparam logic [3:0] OFF_X    = 4'd0;
  localparam logic [3:0] OFF_Y    = 4'd1;
  localparam logic [3:0] OFF_CTRL = 4'd2;
  localparam logic [3:0] OFF_BMP  = 4'd8;
  localparam logic [3:0] G_COLL   = 4'd0;
  localparam logic [3:0] G_STATUS = 4'd1;

  localparam int CTRL_SCALE_BIT = 7;
  localparam int CTRL_EN_BIT    = 4;
  localparam int CTRL_COLOR_MSB = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       scale;
    logic       enable;
    logic [3:0] color;
  } sprite_attr_t;

  function automatic logic [7:0] ctrl_byte(input sprite_attr_t a);
    return {a.scale, 2'b00, a.enable, a.color};
  endfunction

endpackage

// File: rtl/sprite_unit.sv
// rtl/sprite_unit.sv - per-sprite hit test and bitmap lookup
module sprite_unit
  import sprite_pkg::*;
(
  input  sprite_attr_t    attr_i,
  input  logic [7:0][7:0] bitmap_i,
  input  logic [7:0]      hpos_i,
  input  logic [6:0]      vpos_i,
  output logic            opaque_o
);

  logic [7:0] dx;
  logic [6:0] dy;
  logic       in_box;
  logic [2:0] row;
  logic [2:0] col;
  logic [7:0] row_bits;

  // Modular subtraction makes screen-edge wrap fall out for free.
  assign dx = hpos_i - attr_i.x;
  assign dy = vpos_i - attr_i.y;

  assign in_box = attr_i.scale ? (dx[7:4] == 4'd0 && dy[6:4] == 3'd0)
                               : (dx[7:3] == 5'd0 && dy[6:3] == 4'd0);

  assign row      = attr_i.scale ? dy[3:1] : dy[2:0];
  assign col      = attr_i.scale ? dx[3:1] : dx[2:0];
  assign row_bits = bitmap_i[row];
  assign opaque_o = attr_i.enable & in_box & row_bits[3'd7 - col];

endmodule

// File: rtl/sprite_bank.sv
// rtl/sprite_bank.sv - multi-sprite bank with priority, collision and vsync-latched attributes
module sprite_bank
  import sprite_pkg::*;
#(
  parameter  int NSPRITES = 8,
  localparam int IW       = $clog2(NSPRITES),
  localparam int AW       = IW + 5
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [AW-1:0] addr_i,
  input  logic          cs_i,
  input  logic          rw_i,
  input  logic [7:0]    di_i,
  output logic [7:0]    dout_o,
  input  logic [7:0]    hpos_i,
  input  logic [6:0]    vpos_i,
  input  logic          hsync_i,
  input  logic          vsync_i,
  output logic [3:0]    color_o,
  output logic          pixel_o
);

  sprite_attr_t [NSPRITES-1:0]    pend_q, pend_d, act_q, act_d;
  logic [NSPRITES-1:0][7:0][7:0]  bmp_q, bmp_d;
  logic [NSPRITES-1:0]            coll_q, coll_d, opaque;
  logic                           frame_q, frame_d, vs_prev_q;
  logic                           pixel_q, pixel_d;
  logic [3:0]                     color_q, color_d;

  logic          grp;
  logic [IW-1:0] sel;
  logic [3:0]    off;
  logic          wr_en, vs_rise, blank, multi;
  logic [7:0]    coll_byte;

  assign grp     = addr_i[AW-1];
  assign sel     = addr_i[AW-2:4];
  assign off     = addr_i[3:0];
  assign wr_en   = cs_i & ~rw_i;
  assign vs_rise = vsync_i & ~vs_prev_q;
  assign blank   = hsync_i | vsync_i;
  assign multi   = (opaque & (opaque - {{(NSPRITES-1){1'b0}}, 1'b1})) != '0;

  for (genvar g = 0; g < NSPRITES; g++) begin : g_unit
    sprite_unit u_unit (
      .attr_i   (act_q[g]),
      .bitmap_i (bmp_q[g]),
      .hpos_i   (hpos_i),
      .vpos_i   (vpos_i),
      .opaque_o (opaque[g])
    );
  end

  always_comb begin
    pend_d  = pend_q;
    act_d   = act_q;
    bmp_d   = bmp_q;
    coll_d  = coll_q;
    frame_d = frame_q;
    pixel_d = 1'b0;
    color_d = 4'd0;

    // Active copies the pre-write pending set; a coincident write lands next frame.
    if (vs_rise) begin
      act_d   = pend_q;
      frame_d = ~frame_q;
    end

    if (wr_en && !grp) begin
      if (off[3]) begin
        bmp_d[sel][off[2:0]] = di_i;
      end else begin
        case (off)
          OFF_X:    pend_d[sel].x = di_i;
          OFF_Y:    pend_d[sel].y = di_i[6:0];
          OFF_CTRL: begin
            pend_d[sel].scale  = di_i[CTRL_SCALE_BIT];
            pend_d[sel].enable = di_i[CTRL_EN_BIT];
            pend_d[sel].color  = di_i[CTRL_COLOR_MSB:0];
          end
          default: ;
        endcase
      end
    end

    if (wr_en && grp && off == G_COLL) begin
      coll_d = '0;
    end
    if (!blank && multi) begin
      coll_d = coll_d | opaque;
    end

    if (!blank) begin
      pixel_d = |opaque;
      for (int i = NSPRITES - 1; i >= 0; i--) begin
        if (opaque[i]) color_d = act_q[i].color;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q    <= '0;
      act_q     <= '0;
      bmp_q     <= '0;
      coll_q    <= '0;
      frame_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      pixel_q   <= 1'b0;
      color_q   <= 4'd0;
    end else begin
      pend_q    <= pend_d;
      act_q     <= act_d;
      bmp_q     <= bmp_d;
      coll_q    <= coll_d;
      frame_q   <= frame_d;
      vs_prev_q <= vsync_i;
      pixel_q   <= pixel_d;
      color_q   <= color_d;
    end
  end

  if (NSPRITES >= 8) begin : g_coll_wide
    assign coll_byte = coll_q[7:0];
  end else begin : g_coll_narrow
    assign coll_byte = {{(8-NSPRITES){1'b0}}, coll_q};
  end

  always_comb begin
    dout_o = 8'd0;
    if (cs_i) begin
      if (!grp) begin
        if (off[3]) begin
          dout_o = bmp_q[sel][off[2:0]];
        end else begin
          case (off)
            OFF_X:    dout_o = pend_q[sel].x;
            OFF_Y:    dout_o = {1'b0, pend_q[sel].y};
            OFF_CTRL: dout_o = ctrl_byte(pend_q[sel]);
            default:  dout_o = 8'd0;
          endcase
        end
      end else begin
        case (off)
          G_COLL:   dout_o = coll_byte;
          G_STATUS: dout_o = {7'd0, frame_q};
          default:  dout_o = 8'd0;
        endcase
      end
    end
  end

  assign pixel_o = pixel_q;
  assign color_o = color_q;

endmodule
